// File: rtl/ddr3_fb_pkg.sv
// Shared types and sizes for the DDR3 frame-buffer command arbiter.
// Optional two-bank ping-pong is enabled with FB_PINGPONG_EN.
package ddr3_fb_pkg;

  localparam int ADDR_W = 28;
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 11;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT
  } state_t;

  typedef enum logic {
    WR,
    RD
  } grant_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Per-port burst address generator: wrap inside the frame window,
// deferred new-frame load while that port owns the outstanding burst.
module fb_addr_gen
  import ddr3_fb_pkg::*;
#(
  parameter int AW = ddr3_fb_pkg::ADDR_W - 1,
  parameter int LW = ddr3_fb_pkg::LEN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_min,
  input  logic [AW-1:0] addr_max,
  input  logic          load,
  input  logic          busy,
  input  logic          done,
  input  logic [LW-1:0] len,
  input  logic          load_bank,
  output logic [AW-1:0] addr,
  output logic          bank
);

  logic          pending;
  logic [AW:0]   sum;
  logic [AW-1:0] next_addr;

  assign sum = {1'b0, addr} + {{(AW + 1 - LW){1'b0}}, len};

  assign next_addr = (sum >= {1'b0, addr_max})
                   ? addr_min : sum[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= addr_min;
      bank    <= 1'b0;
      pending <= 1'b0;
    end else if (done) begin
      pending <= 1'b0;
      if (pending || load) begin
        addr <= addr_min;
        bank <= load_bank;
      end else begin
        addr <= next_addr;
      end
    end else if (load) begin
      // a repeat load while pending is absorbed
      if (busy) begin
        pending <= 1'b1;
      end else begin
        addr <= addr_min;
        bank <= load_bank;
      end
    end
  end

endmodule

// File: rtl/ddr3_fb_arbiter.sv
// Round-robin DDR3 burst scheduler between camera write and LCD read.
// Define FB_PINGPONG_EN for two alternating frame banks (cmd_addr MSB).
module ddr3_fb_arbiter
  import ddr3_fb_pkg::*;
#(
  parameter int ADDR_W = ddr3_fb_pkg::ADDR_W,
  parameter int LEN_W  = ddr3_fb_pkg::LEN_W,
  parameter int CNT_W  = ddr3_fb_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              rd_enable,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [LEN_W-1:0]  wr_burst_len,
  input  logic [LEN_W-1:0]  rd_burst_len,
  input  logic [ADDR_W-2:0] addr_min,
  input  logic [ADDR_W-2:0] addr_max,
  input  logic [CNT_W-1:0]  wfifo_level,
  input  logic [CNT_W-1:0]  rfifo_space,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              burst_done,
  output logic              wr_bank,
  output logic              rd_bank
);

  state_t            state;
  state_t            state_nx;
  grant_t            last_grant;
  logic              wr_req;
  logic              rd_req;
  logic              grant;
  logic              grant_wr;
  logic [ADDR_W-2:0] wr_addr;
  logic [ADDR_W-2:0] rd_addr;
  logic              wr_busy;
  logic              rd_busy;
  logic              wr_done;
  logic              rd_done;
  logic              wr_lb;
  logic              rd_lb;

  assign wr_req = wfifo_level >= CNT_W'(wr_burst_len);
  assign rd_req = rd_enable
               && (rfifo_space >= CNT_W'(rd_burst_len));

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_wr = 1'b0;
    unique case (state)
      IDLE: begin
        if (init_done && (wr_req || rd_req)) begin
          grant    = 1'b1;
          grant_wr = wr_req
                  && (!rd_req || last_grant == RD);
          state_nx = CMD;
        end
      end
      CMD: begin
        if (cmd_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (burst_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= RD;
      cmd_wr     <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
    end else if (grant) begin
      last_grant <= grant_wr ? WR : RD;
      cmd_wr     <= grant_wr;
      cmd_addr   <= grant_wr ? {wr_bank, wr_addr}
                             : {rd_bank, rd_addr};
      cmd_len    <= grant_wr ? wr_burst_len
                             : rd_burst_len;
    end
  end

  assign cmd_valid = (state == CMD);

  // the grant cycle counts as busy so a load never races the latch
  assign wr_busy = ((state != IDLE) && cmd_wr)
                || (grant && grant_wr);
  assign rd_busy = ((state != IDLE) && !cmd_wr)
                || (grant && !grant_wr);
  assign wr_done = (state == WAIT) && burst_done && cmd_wr;
  assign rd_done = (state == WAIT) && burst_done && !cmd_wr;

`ifdef FB_PINGPONG_EN
  assign wr_lb = ~wr_bank;
  assign rd_lb = ~wr_bank;
`else
  assign wr_lb = 1'b0;
  assign rd_lb = 1'b0;
`endif

  fb_addr_gen #(
    .AW (ADDR_W - 1),
    .LW (LEN_W)
  ) u_wr_gen (
    .clk       (clk),
    .rst       (rst),
    .addr_min  (addr_min),
    .addr_max  (addr_max),
    .load      (wr_load),
    .busy      (wr_busy),
    .done      (wr_done),
    .len       (cmd_len),
    .load_bank (wr_lb),
    .addr      (wr_addr),
    .bank      (wr_bank)
  );

  fb_addr_gen #(
    .AW (ADDR_W - 1),
    .LW (LEN_W)
  ) u_rd_gen (
    .clk       (clk),
    .rst       (rst),
    .addr_min  (addr_min),
    .addr_max  (addr_max),
    .load      (rd_load),
    .busy      (rd_busy),
    .done      (rd_done),
    .len       (cmd_len),
    .load_bank (rd_lb),
    .addr      (rd_addr),
    .bank      (rd_bank)
  );

endmodule

// File: tb/tb_ddr3_fb_arbiter.sv
// Scoreboard bench for ddr3_fb_arbiter: a frame-level reference model
// predicts each command; a monitor checks it while cmd_valid is high.
module tb_ddr3_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        rd_enable;
  logic        wr_load;
  logic        rd_load;
  logic [7:0]  wr_burst_len;
  logic [7:0]  rd_burst_len;
  logic [26:0] addr_min;
  logic [26:0] addr_max;
  logic [10:0] wfifo_level;
  logic [10:0] rfifo_space;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [27:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        burst_done;
  logic        wr_bank;
  logic        rd_bank;

  always #5 clk = ~clk;

  ddr3_fb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .init_done    (init_done),
    .rd_enable    (rd_enable),
    .wr_load      (wr_load),
    .rd_load      (rd_load),
    .wr_burst_len (wr_burst_len),
    .rd_burst_len (rd_burst_len),
    .addr_min     (addr_min),
    .addr_max     (addr_max),
    .wfifo_level  (wfifo_level),
    .rfifo_space  (rfifo_space),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .burst_done   (burst_done),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank)
  );

`ifdef FB_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [27:0] addr;
    logic [7:0]  len;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   errs  = 0;

  // reference model state: frame-level view of each port
  int amin, amax;
  int m_wa, m_ra, m_len;
  bit m_wb, m_rb, m_pw, m_pr;
  bit m_last_rd, m_busy, m_out_wr;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endtask

  function automatic int adv(input int a);
    int s;
    s = a + m_len;
    return (s >= amax) ? amin : s;
  endfunction

  task automatic model_step(input bit lw, input bit lr,
                            input bit done);
    bit owb;
    bit wdone, rdone;
    owb   = m_wb;
    wdone = done && m_busy && m_out_wr;
    rdone = done && m_busy && !m_out_wr;
    if (wdone) begin
      if (m_pw || lw) begin
        m_wa = amin;
        m_wb = PP ? ~owb : 1'b0;
      end else begin
        m_wa = adv(m_wa);
      end
      m_pw = 0;
    end else if (lw) begin
      if (m_busy && m_out_wr) m_pw = 1;
      else begin
        m_wa = amin;
        m_wb = PP ? ~owb : 1'b0;
      end
    end
    if (rdone) begin
      if (m_pr || lr) begin
        m_ra = amin;
        m_rb = PP ? ~owb : 1'b0;
      end else begin
        m_ra = adv(m_ra);
      end
      m_pr = 0;
    end else if (lr) begin
      if (m_busy && !m_out_wr) m_pr = 1;
      else begin
        m_ra = amin;
        m_rb = PP ? ~owb : 1'b0;
      end
    end
    if (done) m_busy = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      tests++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_cmd: wr=%0d addr=%0h len=%0d",
                 cmd_wr, cmd_addr, cmd_len);
      end else begin
        if (cmd_wr !== q[0].wr || cmd_addr !== q[0].addr
            || cmd_len !== q[0].len) begin
          errs++;
          $display("FAIL cmd: got wr=%0d addr=%0h len=%0d expected wr=%0d addr=%0h len=%0d",
                   cmd_wr, cmd_addr, cmd_len,
                   q[0].wr, q[0].addr, q[0].len);
        end
        if (cmd_ready) void'(q.pop_front());
      end
    end
  end

  task automatic idle_window(input int n, input bit loads);
    for (int i = 0; i < n; i++) begin
      wr_load = loads ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_load = loads ? 1'($urandom_range(0, 1)) : 1'b0;
      model_step(wr_load, rd_load, 0);
      @(posedge clk); #1;
      wr_load = 0;
      rd_load = 0;
      chk("no_cmd", cmd_valid, 0);
    end
    chk("wr_bank_idle", wr_bank, m_wb);
    chk("rd_bank_idle", rd_bank, m_rb);
  endtask

  task automatic do_txn(input int rdly, input int wcyc,
                        input int nwl, input bit lr_on,
                        input bit ld_done, input bit drop_init);
    bit   wreq, rreq, gwr, seen;
    exp_t e;
    logic [26:0] a;
    init_done = 1;
    wreq = int'(wfifo_level) >= int'(wr_burst_len);
    rreq = rd_enable && (int'(rfifo_space) >= int'(rd_burst_len));
    if (!wreq && !rreq) begin
      idle_window(4, 1);
      return;
    end
    gwr       = wreq && (!rreq || m_last_rd);
    m_last_rd = !gwr;
    m_out_wr  = gwr;
    m_len     = gwr ? int'(wr_burst_len) : int'(rd_burst_len);
    a         = gwr ? m_wa[26:0] : m_ra[26:0];
    e.wr      = gwr;
    e.addr    = {gwr ? m_wb : m_rb, a};
    e.len     = m_len[7:0];
    q.push_back(e);
    m_busy = 1;
    seen   = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (cmd_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      errs++;
      $display("FAIL cmd_timeout: got no cmd_valid expected a command");
      q.delete();
      m_busy = 0;
      return;
    end
    if (drop_init) init_done = 0;
    repeat (rdly) begin
      @(posedge clk); #1;
    end
    cmd_ready = 1;
    @(posedge clk); #1;
    cmd_ready = 0;
    for (int c = 0; c < wcyc; c++) begin
      wr_load = (c == 0 && nwl > 0) || (c == 2 && nwl > 1);
      rd_load = lr_on && c == 1;
      model_step(wr_load, rd_load, 0);
      @(posedge clk); #1;
      wr_load = 0;
      rd_load = 0;
    end
    chk("wr_bank_pre", wr_bank, m_wb);
    chk("rd_bank_pre", rd_bank, m_rb);
    burst_done = 1;
    wr_load    = ld_done;
    model_step(ld_done, 0, 1);
    @(posedge clk); #1;
    burst_done = 0;
    wr_load    = 0;
    chk("wr_bank_post", wr_bank, m_wb);
    chk("rd_bank_post", rd_bank, m_rb);
    if (drop_init) idle_window(3, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1;
    init_done    = 0;
    rd_enable    = 0;
    wr_load      = 0;
    rd_load      = 0;
    cmd_ready    = 0;
    burst_done   = 0;
    wr_burst_len = 8'd64;
    rd_burst_len = 8'd32;
    wfifo_level  = 0;
    rfifo_space  = 0;
    amin         = 0;
    amax         = 192;
    addr_min     = 27'(amin);
    addr_max     = 27'(amax);
    m_wa = amin;  m_ra = amin;
    m_wb = 0;     m_rb = 0;
    m_pw = 0;     m_pr = 0;
    m_last_rd = 1;
    m_busy = 0;   m_out_wr = 0;  m_len = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_wr", cmd_wr, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_len", cmd_len, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 0);

    wfifo_level = 11'd64;
    idle_window(20, 0);

    repeat (4) do_txn(0, 2, 0, 0, 0, 0);
    do_txn(0, 5, 2, 0, 0, 0);
    do_txn(10, 3, 0, 0, 0, 0);

    rd_enable   = 1;
    rfifo_space = 11'd100;
    repeat (5) do_txn(1, 4, 0, 1, 0, 0);
    do_txn(0, 4, 0, 0, 1, 1);

    amin     = int'($urandom_range(0, 3000));
    amax     = amin + int'($urandom_range(60, 700));
    addr_min = 27'(amin);
    addr_max = 27'(amax);
    rd_enable   = 0;
    wfifo_level = 0;
    wr_load = 1;
    rd_load = 1;
    model_step(1, 1, 0);
    @(posedge clk); #1;
    wr_load = 0;
    rd_load = 0;

    for (int t = 0; t < 60; t++) begin
      wfifo_level  = 11'($urandom_range(0, 300));
      wr_burst_len = 8'($urandom_range(1, 255));
      rd_enable    = 1'($urandom_range(0, 1));
      rfifo_space  = 11'($urandom_range(0, 300));
      rd_burst_len = 8'($urandom_range(1, 255));
      do_txn($urandom_range(0, 4), $urandom_range(4, 8),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0);
    end

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
